// File: rtl/sig_auth_sequencer_pkg.sv
// Shared types and constants for the challenge-response access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sig_auth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHAL,
    ISSUE,
    DECIDE,
    RESP,
    LOCKED
  } auth_state_e;

  // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2 of the shift register.
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  // Consecutive-failure counter increment that sticks at 15.
  function automatic logic [3:0] fail_inc(input logic [3:0] cnt);
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/sig_auth_sequencer_if.sv
// Request / challenge / verifier / grant bundle for sig_auth_sequencer.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and grant_valid/grant_ready handshakes.
interface sig_auth_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_master_id;
  logic       req_mode;
  logic [3:0] req_key;
  logic       req_noise;

  logic       chal_valid;
  logic [3:0] chal_value;
  logic       resp_valid;
  logic [3:0] resp_sig;

  logic       ver_start;
  logic [3:0] ver_sig;
  logic [3:0] ver_key;
  logic       ver_mode;
  logic [1:0] ver_master_id;
  logic [3:0] ver_challenge;
  logic       ver_noise;
  logic       ver_sig_valid;
  logic       ver_inject;

  logic       grant_valid;
  logic       grant_ready;
  logic       grant_ok;
  logic [1:0] grant_id;

  logic       locked;
  logic [3:0] fail_count;
  logic       tamper_alarm;

  // Sequencer side.
  modport slave (
    input  req_valid, req_master_id, req_mode, req_key, req_noise,
    input  resp_valid, resp_sig,
    input  ver_sig_valid, ver_inject,
    input  grant_ready,
    output req_ready, chal_valid, chal_value,
    output ver_start, ver_sig, ver_key, ver_mode, ver_master_id, ver_challenge, ver_noise,
    output grant_valid, grant_ok, grant_id,
    output locked, fail_count, tamper_alarm
  );

  // Requester / verifier side.
  modport master (
    output req_valid, req_master_id, req_mode, req_key, req_noise,
    output resp_valid, resp_sig,
    output ver_sig_valid, ver_inject,
    output grant_ready,
    input  req_ready, chal_valid, chal_value,
    input  ver_start, ver_sig, ver_key, ver_mode, ver_master_id, ver_challenge, ver_noise,
    input  grant_valid, grant_ok, grant_id,
    input  locked, fail_count, tamper_alarm
  );

endinterface

// File: rtl/sig_auth_sequencer_lfsr.sv
// 4-bit Fibonacci LFSR used as the challenge source; never reaches zero from a non-zero seed.
// Latency: new value one cycle after each enabled clock.
// Backpressure: none; free-running while en is high.
module chal_lfsr4
  import sig_auth_pkg::*;
#(
  parameter logic [3:0] SEED = 4'h9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic [3:0] value
);

  // Shift left, feeding back the parity of the tapped bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[2:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/sig_auth_sequencer.sv
// Challenge-response front end: request -> LFSR challenge -> response -> verifier start -> grant/deny.
// Latency: accept to grant_valid = 1 + response wait + 2 cycles (timeout path skips ISSUE/DECIDE).
// Backpressure: req_ready low outside IDLE or when tampered; grant held until grant_ready.
module sig_auth_sequencer
  import sig_auth_pkg::*;
#(
  parameter logic [3:0] LFSR_SEED    = 4'h9,
  parameter int         MAX_FAILS    = 3,
  parameter int         LOCK_CYCLES  = 64,
  parameter int         RESP_TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     resetn,
  sig_auth_if.slave bus
);

  localparam int TMO_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(RESP_TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [3:0]        FAIL_LIMIT = 4'(MAX_FAILS);

  auth_state_e state_q, state_d;

  logic [3:0]        lfsr_val;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [3:0]        fail_q, fail_d;
  logic              tamper_q, tamper_d;
  logic              grant_ok_q, grant_ok_d;
  logic [1:0]        grant_id_q, grant_id_d;
  logic              req_ready_q;

  logic       accept, resp_take, chal_exit, ok;

  // Latched request fields and the registered verifier-facing copies.
  logic [1:0] id_q;
  logic       mode_q, noise_q;
  logic [3:0] key_q, chal_q;
  logic [3:0] ver_sig_q, ver_key_q, ver_chal_q;
  logic [1:0] ver_id_q;
  logic       ver_mode_q, ver_noise_q;

  chal_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .value  (lfsr_val)
  );

  // Next-state, counter and decision logic.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    lock_d     = lock_q;
    fail_d     = fail_q;
    tamper_d   = tamper_q;
    grant_ok_d = grant_ok_q;
    grant_id_d = grant_id_q;
    accept     = 1'b0;
    resp_take  = 1'b0;
    chal_exit  = 1'b0;
    ok         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept  = 1'b1;
          tmo_d   = '0;
          state_d = CHAL;
        end
      end
      CHAL: begin
        // A response arriving in the last allowed cycle still wins over the timeout.
        if (bus.resp_valid) begin
          resp_take = 1'b1;
          chal_exit = 1'b1;
          state_d   = ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          chal_exit  = 1'b1;
          grant_ok_d = 1'b0;
          grant_id_d = id_q;
          fail_d     = fail_inc(fail_q);
          state_d    = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ISSUE: begin
        state_d = DECIDE;
      end
      DECIDE: begin
        // Verifier has registered its result from the ISSUE-cycle start pulse.
        ok         = bus.ver_sig_valid && !bus.ver_inject;
        grant_ok_d = ok;
        grant_id_d = id_q;
        fail_d     = ok ? 4'd0 : fail_inc(fail_q);
        if (bus.ver_inject) begin
          tamper_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.grant_ready) begin
          if (fail_q >= FAIL_LIMIT || tamper_q) begin
            lock_d  = '0;
            state_d = LOCKED;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKED: begin
        // Tamper lockout has no exit other than reset.
        if (!tamper_q) begin
          if (lock_q == LOCK_LAST) begin
            fail_d  = 4'd0;
            state_d = IDLE;
          end else begin
            lock_d = lock_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and decision registers; req_ready registered so it is low during reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      lock_q      <= '0;
      fail_q      <= 4'd0;
      tamper_q    <= 1'b0;
      grant_ok_q  <= 1'b0;
      grant_id_q  <= 2'd0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      lock_q      <= lock_d;
      fail_q      <= fail_d;
      tamper_q    <= tamper_d;
      grant_ok_q  <= grant_ok_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= (state_d == IDLE) && !tamper_d;
    end
  end

  // Capture request fields on accept; publish verifier copies when CHAL is left.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q        <= 2'd0;
      mode_q      <= 1'b0;
      key_q       <= 4'd0;
      noise_q     <= 1'b0;
      chal_q      <= 4'd0;
      ver_sig_q   <= 4'd0;
      ver_key_q   <= 4'd0;
      ver_chal_q  <= 4'd0;
      ver_id_q    <= 2'd0;
      ver_mode_q  <= 1'b0;
      ver_noise_q <= 1'b0;
    end else begin
      if (accept) begin
        id_q    <= bus.req_master_id;
        mode_q  <= bus.req_mode;
        key_q   <= bus.req_key;
        noise_q <= bus.req_noise;
        chal_q  <= lfsr_val;
      end
      if (chal_exit) begin
        ver_sig_q   <= resp_take ? bus.resp_sig : 4'd0;
        ver_key_q   <= key_q;
        ver_chal_q  <= chal_q;
        ver_id_q    <= id_q;
        ver_mode_q  <= mode_q;
        ver_noise_q <= noise_q;
      end
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.chal_valid    = (state_q == CHAL);
  assign bus.chal_value    = chal_q;
  assign bus.ver_start     = (state_q == ISSUE);
  assign bus.ver_sig       = ver_sig_q;
  assign bus.ver_key       = ver_key_q;
  assign bus.ver_mode      = ver_mode_q;
  assign bus.ver_master_id = ver_id_q;
  assign bus.ver_challenge = ver_chal_q;
  assign bus.ver_noise     = ver_noise_q;
  assign bus.grant_valid   = (state_q == RESP);
  assign bus.grant_ok      = grant_ok_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.locked        = (state_q == LOCKED);
  assign bus.fail_count    = fail_q;
  assign bus.tamper_alarm  = tamper_q;

endmodule

// File: tb/tb_sig_auth_sequencer.sv
// Directed bench for sig_auth_sequencer with a behavioural downstream verifier stage.
// Expected grants are queued at stimulus time and popped by an independent monitor.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_sig_auth_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sig_auth_if bus();

  sig_auth_sequencer #(
    .LFSR_SEED    (4'h9),
    .MAX_FAILS    (3),
    .LOCK_CYCLES  (64),
    .RESP_TIMEOUT (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct packed {
    logic       ok;
    logic [1:0] id;
    logic [3:0] fails;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  logic [3:0] m_lfsr;

  // Reference challenge generator: x^4+x^3+1 Fibonacci, seed 4'h9.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 4'h9;
    else         m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end

  // Behavioural signature_verifier_4bit stand-in (SECRET_KEY = 4'hA, authorised master 2'b10).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.ver_sig_valid <= 1'b0;
      bus.ver_inject    <= 1'b0;
    end else if (bus.ver_start) begin
      bus.ver_sig_valid <= bus.ver_mode && (bus.ver_key == 4'hA) && (bus.ver_master_id == 2'b10) &&
                           (bus.ver_sig == ({1'b0, bus.ver_challenge[3:1]} ^ bus.ver_key));
      bus.ver_inject    <= bus.ver_noise;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every grant handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.ver_start) start_cnt++;
      if (bus.grant_valid && bus.grant_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got grant id %0d ok %0d, expected none", bus.grant_id, bus.grant_ok);
        end else begin
          mon_e = sb_q.pop_front();
          check("grant_ok", 32'(bus.grant_ok), 32'(mon_e.ok));
          check("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
          check("fail_count", 32'(bus.fail_count), 32'(mon_e.fails));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic ok, input logic [1:0] id, input logic [3:0] fails);
    exp_t e;
    e.ok = ok;
    e.id = id;
    e.fails = fails;
    sb_q.push_back(e);
  endtask

  // Present a request and return the challenge the reference LFSR predicts for it.
  task automatic do_req(input logic [1:0] id, input logic noise, output logic [3:0] chal);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_master_id = id;
    bus.req_mode = 1'b1;
    bus.req_key = 4'hA;
    bus.req_noise = noise;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept: got req_ready 0 for 200 cycles, expected 1");
    end
    chal = m_lfsr;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Answer the challenge (mask != 0 corrupts the signature) and check the verifier drive.
  task automatic respond(input logic [3:0] chal, input logic [1:0] id, input logic noise, input logic [3:0] mask);
    logic [3:0] sig;
    sig = ({1'b0, chal[3:1]} ^ 4'hA) ^ mask;
    bus.resp_valid = 1'b1;
    bus.resp_sig = sig;
    @(negedge clk);
    check("chal_valid", 32'(bus.chal_valid), 32'd1);
    check("chal_value", 32'(bus.chal_value), 32'(chal));
    tick();
    bus.resp_valid = 1'b0;
    @(negedge clk);
    check("ver_start", 32'(bus.ver_start), 32'd1);
    check("ver_fields", {16'd0, bus.ver_sig, bus.ver_challenge, bus.ver_key, bus.ver_master_id, bus.ver_mode, bus.ver_noise},
          {16'd0, sig, chal, 4'hA, id, 1'b1, noise});
  endtask

  task automatic run_txn(input logic [1:0] id, input logic noise, input logic [3:0] mask,
                         input logic ok, input logic [3:0] fails, output logic [3:0] chal);
    push_exp(ok, id, fails);
    do_req(id, noise, chal);
    respond(chal, id, noise, mask);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("grant_drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {21'd0, bus.chal_valid, bus.req_ready, bus.grant_valid, bus.grant_ok, bus.grant_id,
                            bus.locked, bus.tamper_alarm, bus.ver_start, bus.fail_count}, 32'd0);
    check({name, "_data"}, {10'd0, bus.chal_value, bus.ver_challenge, bus.ver_sig, bus.ver_key,
                            bus.ver_master_id, bus.ver_mode, bus.ver_noise}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] c;
    int n, bad, s0;
    bus.req_valid = 1'b0;
    bus.req_master_id = 2'd0;
    bus.req_mode = 1'b0;
    bus.req_key = 4'd0;
    bus.req_noise = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_sig = 4'd0;
    bus.grant_ready = 1'b1;

    @(negedge clk);
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    tick();
    tick();

    // T1 happy path: third challenge after reset is 4'h6, answer 4'h9.
    run_txn(2'b10, 1'b0, 4'h0, 1'b1, 4'd0, c);
    check("t1_chal_hand", 32'(c), 32'h6);
    wait_drain();

    // T2 wrong master id, with grant held under backpressure.
    bus.grant_ready = 1'b0;
    push_exp(1'b0, 2'b01, 4'd1);
    do_req(2'b01, 1'b0, c);
    respond(c, 2'b01, 1'b0, 4'h0);
    n = 0;
    while (!bus.grant_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (!bus.grant_valid || bus.grant_ok || bus.grant_id != 2'b01) bad++;
    end
    check("t2_grant_hold", 32'(bad), 32'd0);
    tick();
    bus.grant_ready = 1'b1;
    wait_drain();

    // Success clears the failure count.
    run_txn(2'b10, 1'b0, 4'h0, 1'b1, 4'd0, c);
    wait_drain();

    // T3 three bad signatures -> 64-cycle lockout.
    for (int i = 0; i < 3; i++) begin
      run_txn(2'b10, 1'b0, 4'h1, 1'b0, 4'(i + 1), c);
      wait_drain();
    end
    n = 0;
    bad = 0;
    @(negedge clk);
    check("t3_locked", 32'(bus.locked), 32'd1);
    while (bus.locked && n < 200) begin
      n++;
      if (bus.req_ready) bad++;
      @(negedge clk);
    end
    check("t3_lock_cycles", 32'(n), 32'd64);
    check("t3_ready_low", 32'(bad), 32'd0);
    check("t3_after_ready", 32'(bus.req_ready), 32'd1);
    check("t3_after_fails", 32'(bus.fail_count), 32'd0);
    tick();

    // T4 timeout: 16 CHAL cycles, deny, no start pulse.
    s0 = start_cnt;
    push_exp(1'b0, 2'b10, 4'd1);
    do_req(2'b10, 1'b0, c);
    n = 0;
    @(negedge clk);
    while (bus.chal_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t4_chal_cycles", 32'(n), 32'd16);
    wait_drain();
    check("t4_no_start", 32'(start_cnt), 32'(s0));

    // T6 reset in CHAL aborts everything.
    s0 = start_cnt;
    do_req(2'b10, 1'b0, c);
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check_all_zero("t6_reset");
    tick();
    check("t6_no_start", 32'(start_cnt), 32'(s0));
    resetn = 1'b1;
    tick();
    tick();
    run_txn(2'b10, 1'b0, 4'h0, 1'b1, 4'd0, c);
    check("t6_chal_after_reset", 32'(c), 32'h6);
    wait_drain();

    // Response in the final CHAL cycle beats the timeout.
    s0 = start_cnt;
    push_exp(1'b1, 2'b10, 4'd0);
    do_req(2'b10, 1'b0, c);
    repeat (15) tick();
    bus.resp_valid = 1'b1;
    bus.resp_sig = {1'b0, c[3:1]} ^ 4'hA;
    tick();
    bus.resp_valid = 1'b0;
    wait_drain();
    check("t4b_one_start", 32'(start_cnt), 32'(s0 + 1));

    // T5 tamper: valid signature with noise injection -> permanent lock.
    run_txn(2'b10, 1'b1, 4'h0, 1'b0, 4'd1, c);
    wait_drain();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.locked || !bus.tamper_alarm || bus.req_ready) bad++;
    end
    check("t5_stuck_locked", 32'(bad), 32'd0);
    tick();
    resetn = 1'b0;
    #1;
    check("t5_reset_clears", {30'd0, bus.tamper_alarm, bus.locked}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
